// File: rtl/i2s_sample_scheduler.sv
// Paces stereo samples into the I2S transmitter: one sample_valid strobe every CLK_DIV_COUNT clocks,
// sourced from src0, src1 or a saturating mix. Optional macro SCHED_UNDERRUN_COUNT_EN enables underrun_count.
module i2s_sample_scheduler #(
   parameter int CLK_DIV_COUNT = 256,
   parameter int DATA_WIDTH    = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  src0_valid,
   output logic                  src0_ready,
   input  logic [DATA_WIDTH-1:0] src0_left,
   input  logic [DATA_WIDTH-1:0] src0_right,
   input  logic                  src1_valid,
   output logic                  src1_ready,
   input  logic [DATA_WIDTH-1:0] src1_left,
   input  logic [DATA_WIDTH-1:0] src1_right,
   output logic                  sample_valid,
   output logic [DATA_WIDTH-1:0] left_channel,
   output logic [DATA_WIDTH-1:0] right_channel,
   output logic [15:0]           underrun_count
);

   localparam int CW = $clog2(CLK_DIV_COUNT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                state_r;
   logic [CW-1:0]         cnt_r;
   logic                  full0_r;
   logic                  full1_r;
   logic [DATA_WIDTH-1:0] hold0_l_r;
   logic [DATA_WIDTH-1:0] hold0_r_r;
   logic [DATA_WIDTH-1:0] hold1_l_r;
   logic [DATA_WIDTH-1:0] hold1_r_r;
   logic                  sample_valid_r;
   logic [DATA_WIDTH-1:0] left_r;
   logic [DATA_WIDTH-1:0] right_r;

   logic                  req0_s;
   logic                  req1_s;
   logic                  have_all_s;
   logic                  tick_s;
   logic                  consume0_s;
   logic                  consume1_s;
   logic [DATA_WIDTH-1:0] new_l_s;
   logic [DATA_WIDTH-1:0] new_r_s;

   // Signed add in DATA_WIDTH+1 bits, clamped to the representable range
   function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0] sum;
      sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
         sat_add = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         sat_add = sum[DATA_WIDTH-1:0];
      end
   endfunction

   assign src0_ready    = !full0_r;
   assign src1_ready    = !full1_r;
   assign sample_valid  = sample_valid_r;
   assign left_channel  = left_r;
   assign right_channel = right_r;

   // Required sources, tick decode and candidate sample for the live mode
   always_comb begin
      req0_s  = 1'b1;
      req1_s  = 1'b0;
      new_l_s = hold0_l_r;
      new_r_s = hold0_r_r;
      case (mode)
         2'b01: begin
            req0_s  = 1'b0;
            req1_s  = 1'b1;
            new_l_s = hold1_l_r;
            new_r_s = hold1_r_r;
         end
         2'b10: begin
            req0_s  = 1'b1;
            req1_s  = 1'b1;
            new_l_s = sat_add(hold0_l_r, hold1_l_r);
            new_r_s = sat_add(hold0_r_r, hold1_r_r);
         end
         default: begin
            req0_s  = 1'b1;
            req1_s  = 1'b0;
            new_l_s = hold0_l_r;
            new_r_s = hold0_r_r;
         end
      endcase
      have_all_s = (!req0_s || full0_r) && (!req1_s || full1_r);
      tick_s     = enable && (state_r == ST_RUN) && (cnt_r == LAST_CNT);
      consume0_s = tick_s && have_all_s && req0_s;
      consume1_s = tick_s && have_all_s && req1_s;
   end

   // Holding registers: no bypass, so a write can only land while empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full0_r   <= 1'b0;
         full1_r   <= 1'b0;
         hold0_l_r <= '0;
         hold0_r_r <= '0;
         hold1_l_r <= '0;
         hold1_r_r <= '0;
      end else begin
         if (src0_valid && !full0_r) begin
            full0_r   <= 1'b1;
            hold0_l_r <= src0_left;
            hold0_r_r <= src0_right;
         end else if (consume0_s) begin
            full0_r <= 1'b0;
         end else begin
            full0_r <= full0_r;
         end
         if (src1_valid && !full1_r) begin
            full1_r   <= 1'b1;
            hold1_l_r <= src1_left;
            hold1_r_r <= src1_right;
         end else if (consume1_s) begin
            full1_r <= 1'b0;
         end else begin
            full1_r <= full1_r;
         end
      end
   end

   // Scheduler FSM with tick counter and registered sample outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         cnt_r          <= '0;
         sample_valid_r <= 1'b0;
         left_r         <= '0;
         right_r        <= '0;
      end else if (!enable) begin
         state_r        <= ST_IDLE;
         cnt_r          <= '0;
         sample_valid_r <= 1'b0;
         left_r         <= '0;
         right_r        <= '0;
      end else begin
         sample_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               cnt_r   <= '0;
               left_r  <= '0;
               right_r <= '0;
               state_r <= ST_PRIME;
            end
            ST_PRIME: begin
               cnt_r <= '0;
               if (have_all_s) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_PRIME;
               end
            end
            ST_RUN: begin
               if (tick_s) begin
                  cnt_r          <= '0;
                  sample_valid_r <= 1'b1;
                  if (have_all_s) begin
                     left_r  <= new_l_s;
                     right_r <= new_r_s;
                  end else begin
                     left_r  <= left_r;
                     right_r <= right_r;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

`ifdef SCHED_UNDERRUN_COUNT_EN
   logic [15:0] underrun_r;
   logic        underrun_s;

   assign underrun_s     = tick_s && !have_all_s;
   assign underrun_count = underrun_r;

   // Saturating count of ticks that found a required register empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_r <= 16'd0;
      end else if (underrun_s && (underrun_r != 16'hFFFF)) begin
         underrun_r <= underrun_r + 16'd1;
      end else begin
         underrun_r <= underrun_r;
      end
   end
`else
   assign underrun_count = 16'd0;
`endif

endmodule
